// File: rtl/fifo_pkg.sv
// Shared definitions for the read- and write-side controllers of the synchronous UART FIFO.
package fifo_pkg;

   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH = 8;

   typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

   // Occupancy between two binary pointers of ptr_bits width, modulo 2^ptr_bits.
   function automatic logic [31:0] ptr_diff(input logic [31:0] wr,
                                            input logic [31:0] rd,
                                            input int unsigned ptr_bits);
      logic [31:0] mask;
      mask = (32'd1 << ptr_bits) - 32'd1;
      return (wr - rd) & mask;
   endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry first-word-fall-through output buffer (out slot plus skid slot) with valid/ready handshake.
module fifo_out_skid
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  m_ready,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  pop,
   output logic [1:0]            count
);

   logic                  out_vld;
   logic                  skid_vld;
   logic [DATA_WIDTH-1:0] out_reg;
   logic [DATA_WIDTH-1:0] skid_reg;

   assign pop     = out_vld & m_ready;
   assign m_valid = out_vld;
   assign m_data  = out_reg;
   assign count   = {1'b0, out_vld} + {1'b0, skid_vld};

   // NOTE: all state here is updated with non-blocking assignments so every
   // branch reads the pre-edge values of out_vld/skid_vld, never a half-updated mix.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
         out_reg  <= '0;
         skid_reg <= '0;
      end else if (pop) begin
         if (skid_vld) begin
            out_reg <= skid_reg;
            if (in_valid) skid_reg <= in_data;
            else          skid_vld <= 1'b0;
         end else if (in_valid) begin
            out_reg <= in_data;
         end else begin
            out_vld <= 1'b0;
         end
      end else if (in_valid) begin
         if (!out_vld) begin
            out_reg <= in_data;
            out_vld <= 1'b1;
         end else begin
            skid_reg <= in_data;
            skid_vld <= 1'b1;
         end
      end
   end

   // The parent's read throttle guarantees the skid slot is free whenever it is loaded.
   a_skid_free: assert property (@(posedge clk) disable iff (rst)
      !(in_valid && out_vld && !pop && skid_vld));

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: issues RAM reads against the write pointer and feeds a FWFT output buffer.
module fifo_read_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int AE_THRESH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH:0]   wr_ptr,
   output logic [ADDR_WIDTH:0]   rd_ptr,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_req,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   level
);

   localparam int PTR_W = ADDR_WIDTH + 1;

   logic       inflight;
   logic       pop;
   logic [1:0] buf_cnt;
   logic [1:0] held;
   logic [1:0] held_after_pop;

   // Full-width compare: after a wrap the MSB differs, so full never looks empty.
   assign empty        = (rd_ptr == wr_ptr);
   assign rd_addr      = rd_ptr[ADDR_WIDTH-1:0];
   assign level        = PTR_W'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PTR_W));
   assign almost_empty = (int'(level) <= AE_THRESH);

   // Words already committed to the consumer path: buffered plus the one on its way from RAM.
   assign held           = buf_cnt + {1'b0, inflight};
   assign held_after_pop = held - {1'b0, pop};
   assign rd_req         = !empty && (held_after_pop < 2'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= rd_req;
         if (rd_req) rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   fifo_out_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (inflight),
      .in_data  (mem_rdata),
      .m_ready  (m_ready),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .pop      (pop),
      .count    (buf_cnt)
   );

   a_held_max: assert property (@(posedge clk) disable iff (rst) held <= 2'd2);
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(rd_req && empty));

endmodule
